// File: rtl/arc_pkg.sv
// Shared decode definitions for the ARC MIPS core: opcodes, funct codes,
// ALU encodings and the execute-stage control bundle.
package arc_pkg;

  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Field order matters: execute unpacks this bundle MSB first.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
    logic       spare;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/decode_regfile.sv
// 32-entry register file: two combinational read ports with write-through
// bypass, one write port, r0 hardwired to zero, synchronous clear.
module regfile
  import arc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);

  logic [DATA_W-1:0] mem_q [REG_N];
  logic              wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // A write landing on the address being read is returned in the same cycle.
  always_comb begin
    if (ra1_i == '0) begin
      rd1_o = '0;
    end else if (wr_en && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = mem_q[ra1_i];
    end
  end

  always_comb begin
    if (ra2_i == '0) begin
      rd2_o = '0;
    end else if (wr_en && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = mem_q[ra2_i];
    end
  end

endmodule

// File: rtl/decode.sv
// Decode stage: control decode, register read, load-use stall, jump target
// and the ID/EX pipeline register.
module decode
  import arc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_data_Instr,
  input  logic [31:0]       i_addr_NextPC,
  input  logic              i_con_FlushE,
  input  logic              i_con_RegWriteW,
  input  logic [4:0]        i_addr_WriteRegW,
  input  logic [DATA_W-1:0] i_data_ResultW,
  output logic              o_con_Stall,
  output logic              o_con_JumpD,
  output logic [31:0]       o_addr_JumpD,
  output logic [9:0]        o_con_CtrlE,
  output logic [DATA_W-1:0] o_data_Rd1E,
  output logic [DATA_W-1:0] o_data_Rd2E,
  output logic [DATA_W-1:0] o_data_ImmE,
  output logic [31:0]       o_addr_PCPlus4E,
  output logic [4:0]        o_addr_RsE,
  output logic [4:0]        o_addr_RtE,
  output logic [4:0]        o_addr_RdE,
  output logic              o_con_IllegalE
);

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] imm;
  ctrl_t             ctrl_dec;
  logic              illegal_dec;
  logic              stall;
  logic              bubble;

  ctrl_t             ctrl_q,    ctrl_d;
  logic [DATA_W-1:0] rd1_q,     rd1_d;
  logic [DATA_W-1:0] rd2_q,     rd2_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [31:0]       pc4_q,     pc4_d;
  logic [4:0]        rs_q,      rs_d;
  logic [4:0]        rt_q,      rt_d;
  logic [4:0]        rd_q,      rd_d;
  logic              illegal_q, illegal_d;

  assign op    = i_data_Instr[31:26];
  assign rs    = i_data_Instr[25:21];
  assign rt    = i_data_Instr[20:16];
  assign rd    = i_data_Instr[15:11];
  assign funct = i_data_Instr[5:0];
  assign imm   = {{(DATA_W-16){i_data_Instr[15]}}, i_data_Instr[15:0]};

  regfile #(
    .DATA_W(DATA_W),
    .REG_N (REG_N)
  ) u_regfile (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .we_i  (i_con_RegWriteW),
    .wa_i  (i_addr_WriteRegW),
    .wd_i  (i_data_ResultW),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  always_comb begin
    ctrl_dec    = CTRL_BUBBLE;
    illegal_dec = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.reg_dst   = 1'b1;
        unique case (funct)
          FN_ADD:  ctrl_dec.alu_control = ALU_ADD;
          FN_SUB:  ctrl_dec.alu_control = ALU_SUB;
          FN_AND:  ctrl_dec.alu_control = ALU_AND;
          FN_OR:   ctrl_dec.alu_control = ALU_OR;
          FN_SLT:  ctrl_dec.alu_control = ALU_SLT;
          default: begin
            ctrl_dec    = CTRL_BUBBLE;
            illegal_dec = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl_dec.reg_write   = 1'b1;
        ctrl_dec.mem_to_reg  = 1'b1;
        ctrl_dec.alu_src     = 1'b1;
        ctrl_dec.alu_control = ALU_ADD;
      end
      OP_SW: begin
        ctrl_dec.mem_write   = 1'b1;
        ctrl_dec.alu_src     = 1'b1;
        ctrl_dec.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_dec.branch      = 1'b1;
        ctrl_dec.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_dec.reg_write   = 1'b1;
        ctrl_dec.alu_src     = 1'b1;
        ctrl_dec.alu_control = ALU_ADD;
      end
      OP_J:    ctrl_dec = CTRL_BUBBLE;
      default: illegal_dec = 1'b1;
    endcase
  end

  // Conservative load-use check: rt is compared even when unused. A flush
  // squashes the wrong-path instruction, so it must not be held.
  assign stall  = ctrl_q.mem_to_reg && ((rt_q == rs) || (rt_q == rt)) && !i_con_FlushE;
  assign bubble = i_con_FlushE || stall;

  always_comb begin
    ctrl_d    = CTRL_BUBBLE;
    rd1_d     = '0;
    rd2_d     = '0;
    imm_d     = '0;
    pc4_d     = '0;
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    illegal_d = 1'b0;
    if (!bubble) begin
      ctrl_d    = ctrl_dec;
      rd1_d     = rd1;
      rd2_d     = rd2;
      imm_d     = imm;
      pc4_d     = i_addr_NextPC;
      rs_d      = rs;
      rt_d      = rt;
      rd_d      = rd;
      illegal_d = illegal_dec;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_q    <= CTRL_BUBBLE;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      imm_q     <= imm_d;
      pc4_q     <= pc4_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_con_Stall     = stall;
  assign o_con_JumpD     = (op == OP_J);
  assign o_addr_JumpD    = {i_addr_NextPC[31:28], i_data_Instr[25:0], 2'b00};
  assign o_con_CtrlE     = ctrl_q;
  assign o_data_Rd1E     = rd1_q;
  assign o_data_Rd2E     = rd2_q;
  assign o_data_ImmE     = imm_q;
  assign o_addr_PCPlus4E = pc4_q;
  assign o_addr_RsE      = rs_q;
  assign o_addr_RtE      = rt_q;
  assign o_addr_RdE      = rd_q;
  assign o_con_IllegalE  = illegal_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage with hand-computed expected values.
module tb_decode;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_data_Instr;
  logic [31:0] i_addr_NextPC;
  logic        i_con_FlushE;
  logic        i_con_RegWriteW;
  logic [4:0]  i_addr_WriteRegW;
  logic [31:0] i_data_ResultW;
  logic        o_con_Stall;
  logic        o_con_JumpD;
  logic [31:0] o_addr_JumpD;
  logic [9:0]  o_con_CtrlE;
  logic [31:0] o_data_Rd1E;
  logic [31:0] o_data_Rd2E;
  logic [31:0] o_data_ImmE;
  logic [31:0] o_addr_PCPlus4E;
  logic [4:0]  o_addr_RsE;
  logic [4:0]  o_addr_RtE;
  logic [4:0]  o_addr_RdE;
  logic        o_con_IllegalE;

  int n_checks = 0;
  int n_fails  = 0;

  decode dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_data_Instr     (i_data_Instr),
    .i_addr_NextPC    (i_addr_NextPC),
    .i_con_FlushE     (i_con_FlushE),
    .i_con_RegWriteW  (i_con_RegWriteW),
    .i_addr_WriteRegW (i_addr_WriteRegW),
    .i_data_ResultW   (i_data_ResultW),
    .o_con_Stall      (o_con_Stall),
    .o_con_JumpD      (o_con_JumpD),
    .o_addr_JumpD     (o_addr_JumpD),
    .o_con_CtrlE      (o_con_CtrlE),
    .o_data_Rd1E      (o_data_Rd1E),
    .o_data_Rd2E      (o_data_Rd2E),
    .o_data_ImmE      (o_data_ImmE),
    .o_addr_PCPlus4E  (o_addr_PCPlus4E),
    .o_addr_RsE       (o_addr_RsE),
    .o_addr_RtE       (o_addr_RtE),
    .o_addr_RdE       (o_addr_RdE),
    .o_con_IllegalE   (o_con_IllegalE)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string what);
    @(posedge i_clk);
    #1;
    $display("[%0t] step: %s", $time, what);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " CtrlE"},   {22'd0, o_con_CtrlE}, 32'h0);
    chk({tag, " IllegalE"}, {31'd0, o_con_IllegalE}, 32'h0);
    chk({tag, " Rd1E"},    o_data_Rd1E, 32'h0);
    chk({tag, " Rd2E"},    o_data_Rd2E, 32'h0);
    chk({tag, " ImmE"},    o_data_ImmE, 32'h0);
    chk({tag, " PCPlus4E"}, o_addr_PCPlus4E, 32'h0);
    chk({tag, " RsE"},     {27'd0, o_addr_RsE}, 32'h0);
    chk({tag, " RtE"},     {27'd0, o_addr_RtE}, 32'h0);
    chk({tag, " RdE"},     {27'd0, o_addr_RdE}, 32'h0);
  endtask

  initial begin
    i_rst            = 1'b1;
    i_data_Instr     = 32'h0;
    i_addr_NextPC    = 32'h0;
    i_con_FlushE     = 1'b0;
    i_con_RegWriteW  = 1'b0;
    i_addr_WriteRegW = 5'd0;
    i_data_ResultW   = 32'h0;
    tick("reset");
    tick("reset");
    chk_bubble("reset");
    chk("reset Stall", {31'd0, o_con_Stall}, 32'h0);
    i_rst = 1'b0;

    // Preload r1=5, r2=7 through the write-back port.
    i_con_RegWriteW = 1'b1; i_addr_WriteRegW = 5'd1; i_data_ResultW = 32'd5;
    tick("write r1=5");
    i_addr_WriteRegW = 5'd2; i_data_ResultW = 32'd7;
    tick("write r2=7");
    i_con_RegWriteW = 1'b0;

    i_data_Instr = 32'h00221820; i_addr_NextPC = 32'h0000_0100;
    tick("add $3,$1,$2");
    chk("add CtrlE",    {22'd0, o_con_CtrlE}, 32'h214);
    chk("add Rd1E",     o_data_Rd1E, 32'd5);
    chk("add Rd2E",     o_data_Rd2E, 32'd7);
    chk("add RdE",      {27'd0, o_addr_RdE}, 32'd3);
    chk("add RsE",      {27'd0, o_addr_RsE}, 32'd1);
    chk("add RtE",      {27'd0, o_addr_RtE}, 32'd2);
    chk("add ImmE",     o_data_ImmE, 32'h0000_1820);
    chk("add PCPlus4E", o_addr_PCPlus4E, 32'h0000_0100);
    chk("add IllegalE", {31'd0, o_con_IllegalE}, 32'h0);

    // Remaining R-type functs and an unsupported funct.
    i_data_Instr = 32'h00221822; tick("sub");
    chk("sub CtrlE", {22'd0, o_con_CtrlE}, 32'h21C);
    i_data_Instr = 32'h00221824; tick("and");
    chk("and CtrlE", {22'd0, o_con_CtrlE}, 32'h210);
    i_data_Instr = 32'h00221825; tick("or");
    chk("or CtrlE", {22'd0, o_con_CtrlE}, 32'h212);
    i_data_Instr = 32'h0022182A; tick("slt");
    chk("slt CtrlE", {22'd0, o_con_CtrlE}, 32'h21E);
    i_data_Instr = 32'h00221821; tick("bad funct");
    chk("badfn CtrlE",    {22'd0, o_con_CtrlE}, 32'h0);
    chk("badfn IllegalE", {31'd0, o_con_IllegalE}, 32'h1);

    // Write-through bypass of r4, then r0 write ignored.
    i_data_Instr = 32'h00801820;
    i_con_RegWriteW = 1'b1; i_addr_WriteRegW = 5'd4; i_data_ResultW = 32'hDEADBEEF;
    tick("bypass r4");
    chk("bypass Rd1E", o_data_Rd1E, 32'hDEADBEEF);
    chk("bypass Rd2E", o_data_Rd2E, 32'h0);
    i_data_Instr = 32'h00041820;
    i_addr_WriteRegW = 5'd0; i_data_ResultW = 32'h0000_1234;
    tick("write r0");
    chk("r0 Rd1E",     o_data_Rd1E, 32'h0);
    chk("r4 held Rd2E", o_data_Rd2E, 32'hDEADBEEF);
    i_con_RegWriteW = 1'b0; i_addr_WriteRegW = 5'd0; i_data_ResultW = 32'h0;
    tick("r0 reread");
    chk("r0 after Rd1E", o_data_Rd1E, 32'h0);

    // Load-use: lw $5,8($1) then add $6,$5,$2.
    i_data_Instr = 32'h8C250008;
    tick("lw $5,8($1)");
    chk("lw CtrlE", {22'd0, o_con_CtrlE}, 32'h324);
    chk("lw RtE",   {27'd0, o_addr_RtE}, 32'd5);
    chk("lw ImmE",  o_data_ImmE, 32'd8);
    chk("lw Rd1E",  o_data_Rd1E, 32'd5);
    i_data_Instr = 32'h00A23020;
    #1;
    chk("loaduse Stall", {31'd0, o_con_Stall}, 32'h1);
    tick("stall bubble");
    chk("stall CtrlE", {22'd0, o_con_CtrlE}, 32'h0);
    chk("stall RsE",   {27'd0, o_addr_RsE}, 32'h0);
    chk("stall released", {31'd0, o_con_Stall}, 32'h0);
    tick("add $6,$5,$2");
    chk("post-stall CtrlE", {22'd0, o_con_CtrlE}, 32'h214);
    chk("post-stall RsE",   {27'd0, o_addr_RsE}, 32'd5);
    chk("post-stall RdE",   {27'd0, o_addr_RdE}, 32'd6);

    // Flush beats a pending load-use stall.
    i_data_Instr = 32'h8C250008;
    tick("lw again");
    i_data_Instr = 32'h10A00003;
    #1;
    chk("beq hazard Stall", {31'd0, o_con_Stall}, 32'h1);
    i_con_FlushE = 1'b1;
    #1;
    chk("flush Stall", {31'd0, o_con_Stall}, 32'h0);
    tick("flush");
    chk_bubble("flush");
    i_con_FlushE = 1'b0;
    tick("beq $5,$0,3");
    chk("beq CtrlE", {22'd0, o_con_CtrlE}, 32'h04C);
    chk("beq ImmE",  o_data_ImmE, 32'd3);

    // sw and addi with negative immediate.
    i_data_Instr = 32'hAC220004; tick("sw $2,4($1)");
    chk("sw CtrlE", {22'd0, o_con_CtrlE}, 32'h0A4);
    i_data_Instr = 32'h2027FFFF; tick("addi $7,$1,-1");
    chk("addi CtrlE", {22'd0, o_con_CtrlE}, 32'h224);
    chk("addi ImmE",  o_data_ImmE, 32'hFFFF_FFFF);

    // Jump.
    i_data_Instr = 32'h08100004; i_addr_NextPC = 32'h0040_0004;
    #1;
    chk("j JumpD",    {31'd0, o_con_JumpD}, 32'h1);
    chk("j JumpAddr", o_addr_JumpD, 32'h0040_0010);
    tick("j 0x00400010");
    chk("j CtrlE",    {22'd0, o_con_CtrlE}, 32'h0);
    chk("j IllegalE", {31'd0, o_con_IllegalE}, 32'h0);
    chk("j PCPlus4E", o_addr_PCPlus4E, 32'h0040_0004);

    // Unsupported opcode, then reset mid-stream.
    i_data_Instr = 32'hFC000000;
    #1;
    chk("op3f JumpD", {31'd0, o_con_JumpD}, 32'h0);
    tick("opcode 0x3F");
    chk("op3f IllegalE", {31'd0, o_con_IllegalE}, 32'h1);
    chk("op3f CtrlE",    {22'd0, o_con_CtrlE}, 32'h0);
    i_rst = 1'b1;
    i_data_Instr = 32'h00221820;
    tick("reset mid-stream");
    chk_bubble("midreset");
    i_rst = 1'b0;
    tick("add after reset");
    chk("cleared CtrlE", {22'd0, o_con_CtrlE}, 32'h214);
    chk("cleared Rd1E",  o_data_Rd1E, 32'h0);
    chk("cleared Rd2E",  o_data_Rd2E, 32'h0);
    i_data_Instr = 32'h00801820;
    tick("read r4 after reset");
    chk("cleared r4", o_data_Rd1E, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Second pipeline stage of the ARC MIPS core. Consumes the instruction word and PC+4 registered by the fetch stage.
- Reads the 32x32 register file and decodes control. Detects load-use hazards and stalls fetch/decode.
- Registers everything needed by execute into the ID/EX pipeline register.
- Also accepts the write-back port into the register file, and produces the jump target for fetch.

Parameters:
- DATA_W, 32, datapath width.
- REG_N, 32, number of architectural registers. REG_N = 2^5, so the address width is fixed at 5.

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_data_Instr  in  32  instruction from the fetch pipeline register
- i_addr_NextPC  in  32  PC+4 from the fetch pipeline register
- i_con_FlushE  in  1  branch taken in a later stage; squash the ID/EX contents
- i_con_RegWriteW  in  1  write-back enable
- i_addr_WriteRegW  in  5  write-back register address
- i_data_ResultW  in  32  write-back data
- o_con_Stall  out  1  hold PC and the fetch pipeline register this cycle (combinational)
- o_con_JumpD  out  1  current instruction is j (combinational)
- o_addr_JumpD  out  32  {i_addr_NextPC[31:28], instr[25:0], 2'b00} (combinational)
- o_con_CtrlE  out  10  packed control bundle for execute (see package)
- o_data_Rd1E  out  32  rs value
- o_data_Rd2E  out  32  rt value
- o_data_ImmE  out  32  sign-extended instr[15:0]
- o_addr_PCPlus4E  out  32  PC+4 of the instruction in execute
- o_addr_RsE, o_addr_RtE, o_addr_RdE  out  5 each  register fields, for forwarding/destination
- o_con_IllegalE  out  1  instruction in execute was unsupported

Behaviour:
- Reset: all ID/EX outputs are 0, i.e. a bubble. All 32 registers are cleared to 0.

Decode (combinational):
- R-type (op 0x00), ALUControl by funct:
  - 0x20 add -> 010
  - 0x22 sub -> 110
  - 0x24 and -> 000
  - 0x25 or -> 001
  - 0x2A slt -> 111
  - R-type sets RegWrite=1, RegDst=1.
- lw (0x23): RegWrite, MemtoReg, ALUSrc, ALU=010.
- sw (0x2B): MemWrite, ALUSrc, ALU=010.
- beq (0x04): Branch, ALU=110.
- addi (0x08): RegWrite, ALUSrc, ALU=010.
- j (0x02): JumpD=1, control bundle all zero.
- Any other opcode or funct: control bundle all zero, and IllegalE=1 is registered.

Register file:
- Two combinational read ports and one write port. The write occurs at the rising edge when RegWriteW=1 and the address is nonzero.
- r0 always reads 0; writes to r0 are ignored.
- Write-through bypass: if RegWriteW=1, WriteRegW!=0 and WriteRegW equals the read address, the read returns ResultW in the same cycle.

Load-use hazard:
- Stall = CtrlE.MemtoReg AND (RtE==rs OR RtE==rt), where rs=instr[25:21] and rt=instr[20:16].
- The compare is evaluated even for instructions that do not use rt (conservative; this is allowed).
- On stall: o_con_Stall=1, ID/EX loads a bubble (all control and IllegalE zero; data fields don't-care, but are driven to 0).
- Fetch holds its register, so the same instruction is re-decoded next cycle. The stall therefore lasts exactly 1 cycle.

Flush:
- i_con_FlushE=1 loads a bubble into ID/EX at the next edge.
- Flush has priority over stall, and o_con_Stall is forced to 0 while FlushE=1, so the wrong-path instruction is not held.

Other rules:
- Normal latency: decode fields appear on the E outputs one cycle after the instruction is presented.
- Reset asserted mid-operation: the next edge produces a bubble and a cleared register file, regardless of stall or flush.
- A simultaneous write-back and read of the same register returns the new value (bypass); the register itself updates at the edge.

Decomposition:
- Package arc_pkg holds:
  - opcode and funct localparams;
  - ALUControl encodings;
  - ctrl_t packed struct, 10 bits, MSB first: RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, ALUControl[2:0], spare;
  - CTRL_BUBBLE constant (all zero).
- Sub-module: regfile (32x32, 2R/1W, r0 hardwired, write-through bypass, synchronous reset).
- Decode logic, hazard detection and the ID/EX register stay in decode.

Test Plan:
- Reset, then present add $3,$1,$2 (0x00221820) with r1=5, r2=7 preloaded via the write port -> next cycle CtrlE.RegWrite=1, RegDst=1, ALU=010, Rd1E=5, Rd2E=7, RdE=3.
- Write-back of r4=0xDEADBEEF in the same cycle that decode reads r4 -> Rd1E=0xDEADBEEF one cycle later (bypass). Also write r0=0x1234 -> r0 still reads 0.
- lw $5,8($1) followed by add $6,$5,$2:
  - Stall=1 for exactly one cycle and the ID/EX bubble has CtrlE=0.
  - On the next cycle the add is registered with RsE=5.
- beq with FlushE=1 while a load-use hazard is present -> Stall=0 and ID/EX becomes a bubble.
- j 0x0040_0010 with NextPC=0x0040_0004 -> JumpD=1, JumpD addr=0x0040_0010, CtrlE=0 next cycle.
- Unsupported opcode 0x3F, then i_rst mid-stream -> IllegalE=1 with CtrlE=0. After reset all outputs are 0 and registers read 0.
